// File: rtl/router_pkg.sv
// Shared types and helpers for the lookahead router input port.
package router_pkg;

    localparam int unsigned PORTS     = 4;
    localparam int unsigned FLIT_W    = 34;
    localparam int unsigned PAYLOAD_W = 32;
    localparam int unsigned HEAD_BIT  = 33;
    localparam int unsigned TAIL_BIT  = 32;
    localparam int unsigned ROUTE_LSB = 0;

    typedef struct packed {
        logic                 head;
        logic                 tail;
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } input_state_t;

    // Lookahead route must name exactly one output port.
    function automatic logic route_is_onehot(input logic [PORTS-1:0] route);
        return (route != '0) && ((route & (route - PORTS'(1))) == '0);
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Synchronous flit FIFO; front slot is read combinationally, no write-through bypass.
module router_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/router_input_unit.sv
// Router input port: buffers upstream flits, requests the lookahead output port
// for the whole packet and forwards flits on grant with head/tail lock strobes.
module router_input_unit
    import router_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned FLIT_WIDTH = FLIT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [PORTS-1:0]      request,
    input  logic [PORTS-1:0]      grant,
    input  logic [PORTS-1:0]      out_ready,
    output logic [FLIT_WIDTH-1:0] data_out,
    output logic [PORTS-1:0]      data_out_valid,
    output logic                  forwarding_head,
    output logic                  forwarding_tail,
    output logic                  error
);

    input_state_t          r_state;
    input_state_t          w_state_nxt;
    logic [PORTS-1:0]      r_route;
    logic [PORTS-1:0]      w_route_nxt;
    logic                  r_error;
    logic                  w_error_nxt;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [FLIT_WIDTH-1:0] w_front;
    logic                  w_head;
    logic                  w_tail;
    logic [PORTS-1:0]      w_front_route;
    logic                  w_route_ok;
    logic                  w_fire;
    logic [PORTS-1:0]      w_request;
    logic [PORTS-1:0]      w_dov;
    logic                  w_fwd_head;
    logic                  w_fwd_tail;

    assign w_push = data_in_valid & data_in_ready;

    router_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FLIT_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (data_in),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_data  (w_front)
    );

    assign w_head        = w_front[HEAD_BIT];
    assign w_tail        = w_front[TAIL_BIT];
    assign w_front_route = w_front[ROUTE_LSB +: PORTS];
    assign w_route_ok    = route_is_onehot(w_front_route);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_route <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_route <= w_route_nxt;
            r_error <= w_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_route_nxt = r_route;
        w_error_nxt = r_error;
        w_request   = '0;
        w_fire      = 1'b0;
        w_pop       = 1'b0;
        w_dov       = '0;
        w_fwd_head  = 1'b0;
        w_fwd_tail  = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    if (w_head && w_route_ok) begin
                        w_request = w_front_route;
                        w_fire    = |(grant & w_request & out_ready);
                        if (w_fire && !w_tail) begin
                            w_state_nxt = ACTIVE;
                            w_route_nxt = w_front_route;
                        end
                    end else begin
                        // Malformed packet start: discard so the port cannot wedge.
                        w_pop       = 1'b1;
                        w_error_nxt = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                // Request stays up across upstream bubbles until the tail leaves.
                w_request = r_route;
                if (!w_empty) begin
                    w_fire = |(grant & w_request & out_ready);
                    if (w_head) begin
                        w_error_nxt = 1'b1;
                    end
                    if (w_fire && w_tail) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // A stray head inside a packet travels as body so the arbiter lock holds.
        if (w_fire) begin
            w_pop      = 1'b1;
            w_dov      = w_request;
            w_fwd_head = w_head & (r_state == IDLE);
            w_fwd_tail = w_tail;
        end
    end

    assign data_in_ready   = ~w_full;
    assign request         = w_request;
    assign data_out        = w_front;
    assign data_out_valid  = w_dov;
    assign forwarding_head = w_fwd_head;
    assign forwarding_tail = w_fwd_tail;
    assign error           = r_error;

endmodule
